// File: rtl/beam_thresh_sequencer.sv
// rtl/beam_thresh_sequencer.sv - shadow threshold store; streams complemented thresholds to dual-beam units, then one global update
// Optional THRESH_READBACK_EN adds a registered shadow readback port (rd_addr_i/rd_data_o).
module beam_thresh_sequencer #(
    parameter int NBEAMS = 48,
    parameter int TWIDTH = 18,
    parameter int ADDRW  = $clog2(NBEAMS)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [ADDRW-1:0]  wr_addr_i,
    input  logic [TWIDTH-1:0] wr_data_i,
    input  logic              commit_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [TWIDTH-1:0] thresh_o,
    output logic [NBEAMS-1:0] thresh_ce_o,
`ifdef THRESH_READBACK_EN
    input  logic [ADDRW-1:0]  rd_addr_i,
    output logic [TWIDTH-1:0] rd_data_o,
`endif
    output logic              update_o
);

    typedef enum logic [1:0] {IDLE, LOAD, UPDATE, DONE} state_t;

    localparam logic [ADDRW:0]     BEAM_LIMIT = (ADDRW+1)'(NBEAMS);
    localparam logic [ADDRW-1:0]   LAST_IDX   = ADDRW'(NBEAMS - 1);
    localparam logic [NBEAMS-1:0]  CE_ONE     = NBEAMS'(1);

    state_t              state, stateNext;
    logic [ADDRW-1:0]    loadIdx, loadIdxNext;
    logic [TWIDTH-1:0]   shadow [NBEAMS];
    logic [TWIDTH-1:0]   threshNext;
    logic [NBEAMS-1:0]   ceNext;
    logic                updateNext, doneNext, busyNext, readyNext;
    logic                wrAccept;

    // wr_ready_o is registered, so a write landing on the commit edge is already in the shadow when LOAD reads it.
    assign wrAccept = wr_valid_i & wr_ready_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NBEAMS; i++) begin
                shadow[i] <= '1;
            end
        end else if (wrAccept && ({1'b0, wr_addr_i} < BEAM_LIMIT)) begin
            shadow[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        stateNext   = state;
        loadIdxNext = loadIdx;
        threshNext  = '0;
        ceNext      = '0;
        updateNext  = 1'b0;
        doneNext    = 1'b0;
        busyNext    = busy_o;
        readyNext   = wr_ready_o;
        case (state)
            IDLE: begin
                readyNext = 1'b1;
                // The first IDLE cycle after DONE still has wr_ready_o low; commits wait until it reopens.
                if (commit_i && wr_ready_o) begin
                    stateNext   = LOAD;
                    loadIdxNext = '0;
                    busyNext    = 1'b1;
                    readyNext   = 1'b0;
                end
            end
            LOAD: begin
                threshNext = ~shadow[loadIdx] + TWIDTH'(1);
                ceNext     = CE_ONE << loadIdx;
                if (loadIdx == LAST_IDX) begin
                    stateNext = UPDATE;
                end else begin
                    loadIdxNext = loadIdx + ADDRW'(1);
                end
            end
            UPDATE: begin
                updateNext = 1'b1;
                stateNext  = DONE;
            end
            DONE: begin
                doneNext  = 1'b1;
                busyNext  = 1'b0;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            loadIdx     <= '0;
            thresh_o    <= '0;
            thresh_ce_o <= '0;
            update_o    <= 1'b0;
            done_o      <= 1'b0;
            busy_o      <= 1'b0;
            wr_ready_o  <= 1'b1;
        end else begin
            state       <= stateNext;
            loadIdx     <= loadIdxNext;
            thresh_o    <= threshNext;
            thresh_ce_o <= ceNext;
            update_o    <= updateNext;
            done_o      <= doneNext;
            busy_o      <= busyNext;
            wr_ready_o  <= readyNext;
        end
    end

`ifdef THRESH_READBACK_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_o <= '0;
        end else if ({1'b0, rd_addr_i} < BEAM_LIMIT) begin
            rd_data_o <= shadow[rd_addr_i];
        end else begin
            rd_data_o <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_beam_thresh_sequencer.sv
// tb/tb_beam_thresh_sequencer.sv - directed and random checks of beam_thresh_sequencer against a shadow-array model
module tb_beam_thresh_sequencer;

    localparam int NBEAMS = 48;
    localparam int TWIDTH = 18;
    localparam int ADDRW  = 6;
    localparam int TMOD   = 1 << TWIDTH;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDRW-1:0]  wr_addr = '0;
    logic [TWIDTH-1:0] wr_data = '0;
    logic              commit = 1'b0;
    logic              busy, done, update;
    logic [TWIDTH-1:0] thresh;
    logic [NBEAMS-1:0] thresh_ce;
`ifdef THRESH_READBACK_EN
    logic [ADDRW-1:0]  rd_addr = '0;
    logic [TWIDTH-1:0] rd_data;
`endif

    int nChecks = 0;
    int nFail   = 0;
    int shadowM [NBEAMS];

    always #5 clk = ~clk;

    beam_thresh_sequencer #(.NBEAMS(NBEAMS), .TWIDTH(TWIDTH), .ADDRW(ADDRW)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .commit_i    (commit),
        .busy_o      (busy),
        .done_o      (done),
        .thresh_o    (thresh),
        .thresh_ce_o (thresh_ce),
`ifdef THRESH_READBACK_EN
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
`endif
        .update_o    (update)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int load_value(input int s);
        return (TMOD - s) % TMOD;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NBEAMS; i++) shadowM[i] = TMOD - 1;
    endtask

    task automatic write_beam(input int addr, input int data);
        @(negedge clk);
        check("wr_ready_idle", 64'(wr_ready), 64'd1);
        wr_valid = 1'b1;
        wr_addr  = ADDRW'(addr);
        wr_data  = TWIDTH'(data);
        @(posedge clk);
        if (addr < NBEAMS) shadowM[addr] = data % TMOD;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic do_reset_mid_load();
        rst_n = 1'b0;
        #1;
        check("rst_thresh", 64'(thresh), 64'd0);
        check("rst_ce", 64'(thresh_ce), 64'd0);
        check("rst_update", 64'(update), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("rst_no_update", 64'(update), 64'd0);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_release_ready", 64'(wr_ready), 64'd1);
        check("rst_release_busy", 64'(busy), 64'd0);
    endtask

    // One full commit; the expected trace is derived from cycle number and the model shadow.
    task automatic do_commit(input bit sameWr, input int swAddr, input int swData, input bit poke, input int rstAt);
        logic [63:0] expCe;
        @(negedge clk);
        commit = 1'b1;
        if (sameWr) begin
            wr_valid = 1'b1;
            wr_addr  = ADDRW'(swAddr);
            wr_data  = TWIDTH'(swData);
        end
        @(posedge clk);
        if (sameWr && swAddr < NBEAMS) shadowM[swAddr] = swData % TMOD;
        @(negedge clk);
        commit   = 1'b0;
        wr_valid = 1'b0;
        check("c0_busy", 64'(busy), 64'd1);
        check("c0_ready", 64'(wr_ready), 64'd0);
        check("c0_ce", 64'(thresh_ce), 64'd0);
        for (int k = 1; k <= NBEAMS + 3; k++) begin
            if (poke && k >= 2 && k <= 4) begin
                commit   = 1'b1;
                wr_valid = 1'b1;
                wr_addr  = ADDRW'(k);
                wr_data  = TWIDTH'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            commit   = 1'b0;
            wr_valid = 1'b0;
            check($sformatf("c%0d_onehot", k), 64'($onehot0(thresh_ce)), 64'd1);
            check($sformatf("c%0d_upd_ce", k), 64'(update && (thresh_ce != '0)), 64'd0);
            if (k <= NBEAMS) begin
                expCe = 64'd1 << (k - 1);
                check($sformatf("c%0d_ce", k), 64'(thresh_ce), expCe);
                check($sformatf("c%0d_thresh_b%0d", k, k - 1), 64'(thresh), 64'(load_value(shadowM[k - 1])));
                check($sformatf("c%0d_update", k), 64'(update), 64'd0);
                check($sformatf("c%0d_ready", k), 64'(wr_ready), 64'd0);
                check($sformatf("c%0d_busy", k), 64'(busy), 64'd1);
            end else if (k == NBEAMS + 1) begin
                check("upd_ce", 64'(thresh_ce), 64'd0);
                check("upd_update", 64'(update), 64'd1);
                check("upd_busy", 64'(busy), 64'd1);
                check("upd_done", 64'(done), 64'd0);
            end else if (k == NBEAMS + 2) begin
                check("done_update", 64'(update), 64'd0);
                check("done_done", 64'(done), 64'd1);
                check("done_busy", 64'(busy), 64'd0);
                check("done_ready", 64'(wr_ready), 64'd0);
            end else begin
                check("idle_done", 64'(done), 64'd0);
                check("idle_ready", 64'(wr_ready), 64'd1);
                check("idle_busy", 64'(busy), 64'd0);
            end
            if (k == rstAt) begin
                do_reset_mid_load();
                return;
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_thresh", 64'(thresh), 64'd0);
        check("reset_ce", 64'(thresh_ce), 64'd0);
        check("reset_update", 64'(update), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_ready", 64'(wr_ready), 64'd1);

        do_commit(1'b0, 0, 0, 1'b0, 0);

        write_beam(5, 'h00100);
        do_commit(1'b0, 0, 0, 1'b0, 0);

        write_beam(0, 0);
        write_beam(47, 'h3FFFF);
        do_commit(1'b0, 0, 0, 1'b0, 0);

        do_commit(1'b1, 3, 'h00010, 1'b1, 0);

        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 6; w++) begin
                write_beam(int'($urandom_range(0, 63)), int'($urandom_range(0, TMOD - 1)));
            end
            do_commit(1'b0, 0, 0, 1'b0, 0);
        end

        write_beam(9, 'h0ABCD);
        do_commit(1'b0, 0, 0, 1'b0, 20);
        do_commit(1'b0, 0, 0, 1'b0, 0);

`ifdef THRESH_READBACK_EN
        write_beam(10, 'h12345);
        rd_addr = 6'd10;
        @(negedge clk);
        check("rd_beam10", 64'(rd_data), 64'h12345);
        rd_addr = 6'd60;
        @(negedge clk);
        check("rd_out_of_range", 64'(rd_data), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
